jtag_sequencer: RTL and testbench
=================================

JTAG_SEQUENCER -- requirements
Module: jtag_sequencer

Interface
REQ-001 SHALL have parameter TICK_DELAY, default 4: each TCK phase (low or high) lasts TICK_DELAY+1 clock cycles.
REQ-002 SHALL have port clock, input, 1: the single clock of the block.
REQ-003 SHALL have port reset, input, 1: reset, synchronous to clock and active-high.
REQ-004 SHALL have port req_valid, input, 1: a shift command is offered.
REQ-005 SHALL have port req_ready, output, 1: the block can accept a command this cycle.
REQ-006 SHALL have port req_ir, input, 1: 1 selects an IR scan, 0 selects a DR scan.
REQ-007 SHALL have port req_len, input, 7: scan length in bits; legal range is 1..64.
REQ-008 SHALL have port req_data, input, 64: TDI bits, shifted LSB first.
REQ-009 SHALL have port resp_valid, input/output direction output, 1: a response is pending.
REQ-010 SHALL have port resp_ready, input, 1: the consumer accepts the response.
REQ-011 SHALL have port resp_data, output, 64: captured TDO bits, right-aligned.
REQ-012 SHALL have port resp_err, output, 1: the command was illegal.
REQ-013 SHALL have port busy, output, 1: the block is not in IDLE.
REQ-014 SHALL have ports jtag_TCK, jtag_TMS, jtag_TDI and jtag_TRSTn, each an output of width 1, driving the JTAG pins.
REQ-015 SHALL have port jtag_TDO, input, 1: JTAG data returned from the target.

Function
REQ-016 SHALL use the FSM states TLR_WALK, IDLE, PRE, SHIFT, POST and RESP.
REQ-017 SHALL drive req_ready high only in IDLE while resp_valid is 0; a command is accepted when req_valid and req_ready are both high.
REQ-018 SHALL, on accepting a command with req_len equal to 0 or greater than 64, enter RESP on the next cycle with resp_err=1 and resp_data=0, and SHALL not toggle TCK.
REQ-019 SHALL change TMS and TDI only at a TCK falling edge, and SHALL sample TDO at a TCK rising edge.
REQ-020 SHALL, in PRE, drive TMS as 1,0,0 for a DR scan or as 1,1,0,0 for an IR scan (walk from Run-Test/Idle to Shift).
REQ-021 SHALL, in SHIFT, present req_data bit i in TCK cycle i, with TMS=0 in every cycle except the last, where TMS=1.
REQ-022 SHALL, in POST, drive TMS as 1 then 0 (Update, then Idle).
REQ-023 SHALL place the TDO bit sampled in shift cycle i into resp_data bit i; bits at len and above SHALL be 0.
REQ-024 SHALL produce N = len+5 TCK cycles for a DR scan and N = len+6 for an IR scan; resp_valid SHALL rise 2*(TICK_DELAY+1)*N+1 cycles after acceptance.
REQ-025 SHALL hold TCK low in IDLE and RESP.
REQ-026 SHALL hold resp_valid, resp_data and resp_err stable until resp_ready is high, then return to IDLE on the next cycle.
REQ-027 SHALL use a 7-bit bit counter and SHALL handle len=64 without wrap-around.
REQ-028 SHALL keep req_ready low when req_valid arrives while busy; the request is not lost and waits for req_ready.

Reset
REQ-029 SHALL, under reset, set the outputs to: jtag_TCK=0, jtag_TMS=1, jtag_TDI=0, jtag_TRSTn=0, req_ready=0, resp_valid=0, resp_data=0, resp_err=0, busy=1.
REQ-030 SHALL set jtag_TRSTn=1 from the first cycle after reset deasserts.
REQ-031 SHALL, on reset during any state, abort the scan immediately and issue no response.

Configuration
REQ-032 SHALL provide macro JTAG_SEQ_TLR_WALK_EN: when defined, after reset the block SHALL pass through TLR_WALK, driving 5 TCK cycles with TMS=1 and then 1 TCK cycle with TMS=0, before entering IDLE.
REQ-033 SHALL, when JTAG_SEQ_TLR_WALK_EN is undefined, enter IDLE directly on the first cycle after reset.

Verification
REQ-034 SHALL cover: TICK_DELAY=1, TDO looped back to TDI, DR scan with len=8 and data=0xA5 -> resp_data=0xA5, resp_err=0, resp_valid 53 cycles after acceptance.
REQ-035 SHALL cover: IR scan with len=5 and data=0x11 -> TMS sequence 1,1,0,0,0,0,0,0,1,1,0 and 11 TCK rising edges.
REQ-036 SHALL cover: len=0 and len=65 -> resp_err=1 and resp_data=0 on the next cycle, with no TCK edge.
REQ-037 SHALL cover: len=64, TDO looped back, data=0x8000_0000_0000_0001 -> the same value returned, and exactly 69 TCK rising edges.
REQ-038 SHALL cover: reset asserted during SHIFT bit 3 -> outputs at their reset values next cycle, and no resp_valid.
REQ-039 SHALL cover: resp_ready held low for 10 cycles -> resp held stable and req_ready=0 throughout; then with the macro defined, reset -> 6 TCK cycles with TMS=1,1,1,1,1,0 before req_ready rises.

Source files
------------

// File: rtl/jtag_sequencer.sv
// jtag_sequencer: turns IR/DR shift commands into paced TCK/TMS/TDI waveforms and captures TDO.
// Define JTAG_SEQ_TLR_WALK_EN to walk the TAP through Test-Logic-Reset to Run-Test/Idle after reset.
module jtag_sequencer #(
   parameter int TICK_DELAY = 4
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_ir,
   input  logic [6:0]  req_len,
   input  logic [63:0] req_data,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic [63:0] resp_data,
   output logic        resp_err,
   output logic        busy,
   output logic        jtag_TCK,
   output logic        jtag_TMS,
   output logic        jtag_TDI,
   output logic        jtag_TRSTn,
   input  logic        jtag_TDO
);
   localparam int CW = $clog2(TICK_DELAY + 2);
   typedef enum logic [2:0] {TLR_WALK, IDLE, PRE, SHIFT, POST, RESP} state_t;
   state_t state, state_next;
   logic [CW-1:0] cnt;
   logic [6:0] bitc, len;
   logic [63:0] sh, cap;
   logic ir, err, tick, active, rise, fall, bad, last_pre, last_shift, last_post;
   assign tick = cnt == CW'(TICK_DELAY);
`ifdef JTAG_SEQ_TLR_WALK_EN
   assign active = state inside {TLR_WALK, PRE, SHIFT, POST};
`else
   assign active = state inside {PRE, SHIFT, POST};
`endif
   assign rise = active && tick && !jtag_TCK;
   assign fall = active && tick && jtag_TCK;
   assign bad = req_len == 7'd0 || req_len > 7'd64;
   assign last_pre = bitc == (ir ? 7'd3 : 7'd2);
   assign last_shift = bitc + 7'd1 == len;
   assign last_post = bitc == 7'd1;
   assign req_ready = state == IDLE;
   assign busy = state != IDLE;
   assign resp_valid = state == RESP;
   assign resp_data = cap;
   assign resp_err = err;
   always_ff @(posedge clock) begin
      if (reset) state <= TLR_WALK;
      else state <= state_next;
   end
   always_comb begin
      state_next = state;
      case (state)
         TLR_WALK:
`ifdef JTAG_SEQ_TLR_WALK_EN
            if (fall && bitc == 7'd5) state_next = IDLE;
`else
            state_next = IDLE;
`endif
         IDLE:  if (req_valid) state_next = bad ? RESP : PRE;
         PRE:   if (fall && last_pre) state_next = SHIFT;
         SHIFT: if (fall && last_shift) state_next = POST;
         POST:  if (fall && last_post) state_next = RESP;
         RESP:  if (resp_ready) state_next = IDLE;
         default: state_next = TLR_WALK;
      endcase
   end
   // cnt starts at all-ones so the first low phase gets one extra setup cycle
   always_ff @(posedge clock) begin
      if (reset) begin
         jtag_TCK <= 1'b0;
         jtag_TMS <= 1'b1;
         jtag_TDI <= 1'b0;
         jtag_TRSTn <= 1'b0;
         cnt <= '1;
         bitc <= '0;
         len <= '0;
         ir <= 1'b0;
         err <= 1'b0;
         sh <= '0;
         cap <= '0;
      end else begin
         jtag_TRSTn <= 1'b1;
         if (state == IDLE && req_valid) begin
            len <= req_len;
            ir <= req_ir;
            sh <= req_data;
            cap <= '0;
            err <= bad;
            bitc <= '0;
            cnt <= '1;
            if (!bad) jtag_TMS <= 1'b1;
         end else if (active) begin
            cnt <= tick ? '0 : cnt + CW'(1);
            if (tick) jtag_TCK <= !jtag_TCK;
            if (rise && state == SHIFT) cap[bitc[5:0]] <= jtag_TDO;
            if (fall) begin
               bitc <= bitc + 7'd1;
               case (state)
                  PRE: begin
                     jtag_TMS <= last_pre ? len == 7'd1 : ir && bitc == 7'd0;
                     if (last_pre) begin
                        bitc <= '0;
                        jtag_TDI <= sh[0];
                     end
                  end
                  SHIFT: begin
                     jtag_TMS <= last_shift || bitc + 7'd2 == len;
                     jtag_TDI <= !last_shift && sh[1];
                     sh <= sh >> 1;
                     if (last_shift) bitc <= '0;
                  end
                  POST: jtag_TMS <= 1'b0;
                  default: jtag_TMS <= bitc < 7'd4;
               endcase
            end
         end
      end
   end
endmodule

// File: tb/tb_jtag_sequencer.sv
// tb_jtag_sequencer: randomized self-checking bench; expectations come from the scan rules applied to a TCK-edge trace.
module tb_jtag_sequencer;
   localparam int TD = 1;
   logic clock = 1'b0, reset = 1'b1;
   logic req_valid = 1'b0, req_ir = 1'b0, resp_ready = 1'b0;
   logic [6:0] req_len = '0;
   logic [63:0] req_data = '0;
   logic req_ready, resp_valid, resp_err, busy;
   logic [63:0] resp_data;
   logic jtag_TCK, jtag_TMS, jtag_TDI, jtag_TRSTn, jtag_TDO;
   logic loop = 1'b0, tdo_r = 1'b0, mon = 1'b0, p_tms = 1'b1, p_tdi = 1'b0;
   logic tms_q[$], tdi_q[$], tdo_q[$];
   int n_pass = 0, n_total = 0, viol = 0;

   jtag_sequencer #(.TICK_DELAY(TD)) dut (
      .clock(clock), .reset(reset), .req_valid(req_valid), .req_ready(req_ready), .req_ir(req_ir),
      .req_len(req_len), .req_data(req_data), .resp_valid(resp_valid), .resp_ready(resp_ready),
      .resp_data(resp_data), .resp_err(resp_err), .busy(busy), .jtag_TCK(jtag_TCK), .jtag_TMS(jtag_TMS),
      .jtag_TDI(jtag_TDI), .jtag_TRSTn(jtag_TRSTn), .jtag_TDO(jtag_TDO)
   );

   always #5 clock = ~clock;
   assign jtag_TDO = loop ? jtag_TDI : tdo_r;
   // target model: TDO changes on falling TCK
   always @(negedge jtag_TCK) tdo_r = 1'($urandom);
   always @(posedge jtag_TCK) if (mon) begin
      tms_q.push_back(jtag_TMS);
      tdi_q.push_back(jtag_TDI);
      tdo_q.push_back(jtag_TDO);
   end
   always @(negedge clock) begin
      if (jtag_TCK === 1'b1 && (jtag_TMS !== p_tms || jtag_TDI !== p_tdi)) viol++;
      p_tms = jtag_TMS;
      p_tdi = jtag_TDI;
   end

   function automatic logic exp_tms(input logic ir, input int len, input int k);
      int pre = ir ? 4 : 3;
      if (k < pre) return ir ? k < 2 : k == 0;
      if (k < pre + len) return k == pre + len - 1;
      return k == pre + len;
   endfunction

   task automatic issue(input logic ir, input logic [6:0] len, input logic [63:0] data,
                        output int lat, output logic [63:0] rd, output logic re);
      int k;
      tms_q.delete();
      tdi_q.delete();
      tdo_q.delete();
      mon = 1'b1;
      lat = -1;
      rd = 'x;
      re = 1'bx;
      @(negedge clock);
      resp_ready = 1'b0;
      req_valid = 1'b1;
      req_ir = ir;
      req_len = len;
      req_data = data;
      k = 0;
      while (!req_ready && k < 300) begin
         @(negedge clock);
         k++;
      end
      if (!req_ready) begin
         req_valid = 1'b0;
         return;
      end
      @(negedge clock);
      req_valid = 1'b0;
      for (k = 0; k < 1000; k++) begin
         if (resp_valid) begin
            lat = k;
            rd = resp_data;
            re = resp_err;
            return;
         end
         @(negedge clock);
      end
   endtask

   task automatic release_resp();
      @(negedge clock);
      resp_ready = 1'b1;
      @(negedge clock);
      resp_ready = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (3) @(negedge clock);
      n_total++;
      if ({jtag_TCK, jtag_TMS, jtag_TDI, jtag_TRSTn, req_ready, resp_valid, resp_err, busy} !== 8'b0100_0001)
         $display("FAIL reset_outputs got %b want 01000001",
                  {jtag_TCK, jtag_TMS, jtag_TDI, jtag_TRSTn, req_ready, resp_valid, resp_err, busy});
      else n_pass++;
      n_total++;
      if (resp_data !== 64'd0) $display("FAIL reset_resp_data got %h want 0", resp_data);
      else n_pass++;
      reset = 1'b0;
      @(negedge clock);
      n_total++;
      if (jtag_TRSTn !== 1'b1) $display("FAIL trstn_release got %b want 1", jtag_TRSTn);
      else n_pass++;
`ifndef JTAG_SEQ_TLR_WALK_EN
      n_total++;
      if ({req_ready, busy} !== 2'b10) $display("FAIL idle_after_reset got %b want 10", {req_ready, busy});
      else n_pass++;
`endif
   endtask

`ifdef JTAG_SEQ_TLR_WALK_EN
   task automatic test_tlr_walk();
      int k;
      logic [5:0] got;
      reset = 1'b1;
      repeat (2) @(negedge clock);
      tms_q.delete();
      mon = 1'b1;
      reset = 1'b0;
      k = 0;
      while (!req_ready && k < 200) begin
         @(negedge clock);
         k++;
      end
      got = '0;
      for (int i = 0; i < 6 && i < tms_q.size(); i++) got[i] = tms_q[i];
      n_total++;
      if (tms_q.size() != 6 || got !== 6'b011111 || !req_ready)
         $display("FAIL tlr_walk got %0d edges tms %b ready %b want 6 edges tms 011111 ready 1", tms_q.size(), got, req_ready);
      else n_pass++;
   endtask
`endif

   task automatic test_dr_loopback();
      int lat;
      logic [63:0] rd;
      logic re;
      loop = 1'b1;
      issue(1'b0, 7'd8, 64'hA5, lat, rd, re);
      loop = 1'b0;
      n_total++;
      if (rd !== 64'hA5 || re !== 1'b0) $display("FAIL dr_a5_data got %h err %b want a5 err 0", rd, re);
      else n_pass++;
      n_total++;
      if (lat !== 53) $display("FAIL dr_a5_latency got %0d want 53", lat);
      else n_pass++;
      n_total++;
      if (tms_q.size() != 13) $display("FAIL dr_a5_edges got %0d want 13", tms_q.size());
      else n_pass++;
      n_total++;
      if (jtag_TCK !== 1'b0) $display("FAIL tck_low_in_resp got %b want 0", jtag_TCK);
      else n_pass++;
      release_resp();
   endtask

   task automatic test_ir5();
      int lat, mism;
      logic [63:0] rd, er;
      logic re;
      logic exp_seq [11] = '{1, 1, 0, 0, 0, 0, 0, 0, 1, 1, 0};
      logic [4:0] d = 5'h11;
      issue(1'b1, 7'd5, 64'h11, lat, rd, re);
      mism = 0;
      er = '0;
      for (int i = 0; i < 11 && i < tms_q.size(); i++) if (tms_q[i] !== exp_seq[i]) mism++;
      for (int i = 0; i < 5 && i + 4 < tms_q.size(); i++) begin
         if (tdi_q[i + 4] !== d[i]) mism++;
         er[i] = tdo_q[i + 4];
      end
      n_total++;
      if (tms_q.size() != 11 || mism != 0) $display("FAIL ir5_sequence got %0d edges %0d bit errors want 11 edges 0 errors", tms_q.size(), mism);
      else n_pass++;
      n_total++;
      if (rd !== er || re !== 1'b0) $display("FAIL ir5_capture got %h err %b want %h err 0", rd, re, er);
      else n_pass++;
      n_total++;
      if (lat !== 45) $display("FAIL ir5_latency got %0d want 45", lat);
      else n_pass++;
      release_resp();
   endtask

   task automatic test_bad_len();
      int lat;
      logic [63:0] rd;
      logic re;
      logic [6:0] lens [2] = '{7'd0, 7'd65};
      foreach (lens[j]) begin
         issue(1'($urandom), lens[j], {$urandom, $urandom}, lat, rd, re);
         n_total++;
         if (re !== 1'b1 || rd !== 64'd0) $display("FAIL bad_len_%0d_resp got %h err %b want 0 err 1", lens[j], rd, re);
         else n_pass++;
         n_total++;
         if (lat !== 0 || tms_q.size() != 0) $display("FAIL bad_len_%0d_timing got lat %0d edges %0d want 0 0", lens[j], lat, tms_q.size());
         else n_pass++;
         release_resp();
      end
   endtask

   task automatic test_len64();
      int lat;
      logic [63:0] rd;
      logic re;
      loop = 1'b1;
      issue(1'b0, 7'd64, 64'h8000_0000_0000_0001, lat, rd, re);
      loop = 1'b0;
      n_total++;
      if (rd !== 64'h8000_0000_0000_0001 || re !== 1'b0) $display("FAIL len64_data got %h err %b want 8000000000000001 err 0", rd, re);
      else n_pass++;
      n_total++;
      if (tms_q.size() != 69 || lat !== 277) $display("FAIL len64_edges got %0d edges lat %0d want 69 277", tms_q.size(), lat);
      else n_pass++;
      release_resp();
   endtask

   task automatic test_random();
      int lat, len, pre, n, mism;
      logic [63:0] rd, d, er;
      logic re, ir;
      for (int it = 0; it < 12; it++) begin
         ir = 1'($urandom);
         len = it == 0 ? 1 : it == 1 ? 64 : $urandom_range(1, 64);
         d = {$urandom, $urandom};
         issue(ir, 7'(len), d, lat, rd, re);
         pre = ir ? 4 : 3;
         n = pre + len + 2;
         mism = 0;
         er = '0;
         if (tms_q.size() == n) begin
            for (int k = 0; k < n; k++) if (tms_q[k] !== exp_tms(ir, len, k)) mism++;
            for (int k = 0; k < len; k++) begin
               if (tdi_q[pre + k] !== d[k]) mism++;
               er[k] = tdo_q[pre + k];
            end
         end
         n_total++;
         if (tms_q.size() != n || mism != 0)
            $display("FAIL rand%0d_wave got %0d edges %0d bit errors want %0d edges 0 errors", it, tms_q.size(), mism, n);
         else n_pass++;
         n_total++;
         if (rd !== er || re !== 1'b0) $display("FAIL rand%0d_data got %h err %b want %h err 0", it, rd, re, er);
         else n_pass++;
         n_total++;
         if (lat !== 2 * (TD + 1) * n + 1) $display("FAIL rand%0d_latency got %0d want %0d", it, lat, 2 * (TD + 1) * n + 1);
         else n_pass++;
         release_resp();
      end
   endtask

   task automatic test_backpressure();
      int lat, stable;
      logic [63:0] rd, rd2, er;
      logic re, re2;
      issue(1'b0, 7'd10, {$urandom, $urandom}, lat, rd, re);
      stable = 0;
      for (int c = 0; c < 10; c++) begin
         @(negedge clock);
         req_valid = 1'b1;
         req_ir = 1'b1;
         req_len = 7'd3;
         req_data = 64'h5;
         if ({resp_valid, req_ready, resp_err, resp_data} === {2'b10, re, rd}) stable++;
      end
      n_total++;
      if (stable != 10) $display("FAIL stall_hold got %0d stable cycles want 10", stable);
      else n_pass++;
      @(negedge clock);
      resp_ready = 1'b1;
      issue(1'b1, 7'd3, 64'h5, lat, rd2, re2);
      er = {61'd0, tdo_q.size() == 9 ? {tdo_q[6], tdo_q[5], tdo_q[4]} : 3'bxxx};
      n_total++;
      if (lat !== 37 || rd2 !== er || re2 !== 1'b0) $display("FAIL queued_req got lat %0d data %h want lat 37 data %h", lat, rd2, er);
      else n_pass++;
      release_resp();
   endtask

   task automatic test_abort();
      int k, seen;
      @(negedge clock);
      tms_q.delete();
      mon = 1'b1;
      req_valid = 1'b1;
      req_ir = 1'b0;
      req_len = 7'd16;
      req_data = {$urandom, $urandom};
      k = 0;
      while (!req_ready && k < 300) begin
         @(negedge clock);
         k++;
      end
      @(negedge clock);
      req_valid = 1'b0;
      k = 0;
      while (tms_q.size() < 7 && k < 300) begin
         @(negedge clock);
         k++;
      end
      n_total++;
      if (tms_q.size() != 7 || jtag_TCK !== 1'b1) $display("FAIL abort_reach_bit3 got %0d edges tck %b want 7 tck 1", tms_q.size(), jtag_TCK);
      else n_pass++;
      reset = 1'b1;
      @(negedge clock);
      n_total++;
      if ({jtag_TCK, jtag_TMS, jtag_TDI, jtag_TRSTn, req_ready, resp_valid, resp_err, busy, resp_data} !== {8'b0100_0001, 64'd0})
         $display("FAIL abort_outputs got %b %h want 01000001 0",
                  {jtag_TCK, jtag_TMS, jtag_TDI, jtag_TRSTn, req_ready, resp_valid, resp_err, busy}, resp_data);
      else n_pass++;
      reset = 1'b0;
      seen = 0;
      repeat (150) begin
         @(negedge clock);
         if (resp_valid) seen++;
      end
      n_total++;
      if (seen != 0 || !req_ready) $display("FAIL abort_no_resp got %0d resp cycles ready %b want 0 ready 1", seen, req_ready);
      else n_pass++;
   endtask

   task automatic test_edges();
      n_total++;
      if (viol != 0) $display("FAIL tms_tdi_timing got %0d changes while TCK high want 0", viol);
      else n_pass++;
   endtask

   initial begin
      test_reset();
`ifdef JTAG_SEQ_TLR_WALK_EN
      test_tlr_walk();
`endif
      test_dr_loopback();
      test_ir5();
      test_bad_len();
      test_len64();
      test_random();
      test_backpressure();
      test_abort();
      test_edges();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
